// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, reset PC, PC step and word widths.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] RESET_PC = 32'h0;
    localparam logic [INSTR_W-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SKID  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // Instruction parked while decode is blocked
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } skid_entry_t;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with valid bit; flush beats load, load beats consume.
import mips_pkg::*;

module ifid_reg (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               load,
    input  logic               flush,
    input  logic               consume,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [INSTR_W-1:0] d_pc,
    input  logic [INSTR_W-1:0] d_pc4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc4
);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
            pc4   <= d_pc4;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: PC control, imem req/ack, IF/ID register, skid buffer, redirect drain.
// Optional misaligned-redirect exception enabled by defining FETCH_MISALIGN_CHK_EN.
import mips_pkg::*;

module instr_fetch (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_next,
    output logic        o_pc_hold,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_id_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_ifid_valid,
    output logic [31:0] o_ifid_instr,
    output logic [31:0] o_ifid_pc,
    output logic [31:0] o_ifid_pc4,
    output logic        o_exc_misalign
);

    fetch_state_e state, state_nxt;
    skid_entry_t  skid_q;
    logic [INSTR_W-1:0] r_drain_addr;

    logic accept;
    logic redirect_fire;
    logic skid_load;
    logic drain_load;
    logic ifid_load;
    logic ifid_flush;
    logic ifid_consume;
    logic use_skid;
    logic [INSTR_W-1:0] ld_instr, ld_pc, ld_pc4;

    assign accept        = !o_ifid_valid || !i_id_stall;
    assign ifid_consume  = o_ifid_valid && !i_id_stall;
    // IDLE only exists for the cycle after reset, before any fetch is in flight
    assign redirect_fire = i_redirect && (state != IDLE);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        o_pc_next   = i_pc;
        o_pc_hold   = 1'b1;
        o_imem_req  = 1'b0;
        o_imem_addr = '0;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        use_skid    = 1'b0;
        skid_load   = 1'b0;
        drain_load  = 1'b0;

        if (redirect_fire) begin
            o_pc_next  = i_redirect_pc;
            o_pc_hold  = 1'b0;
            ifid_flush = 1'b1;
        end

        case (state)
            IDLE: begin
                o_pc_next = RESET_PC;
                state_nxt = REQ;
            end
            REQ: begin
                o_imem_req  = 1'b1;
                o_imem_addr = i_pc;
                if (redirect_fire) begin
                    if (!i_imem_ack) begin
                        drain_load = 1'b1;
                        state_nxt  = DRAIN;
                    end else begin
                        state_nxt  = REQ;
                    end
                end else if (i_imem_ack) begin
                    o_pc_next = i_pc + PC_STEP;
                    o_pc_hold = 1'b0;
                    if (accept) begin
                        ifid_load = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_nxt = SKID;
                    end
                end
            end
            SKID: begin
                if (redirect_fire) begin
                    state_nxt = REQ;
                end else if (accept) begin
                    ifid_load = 1'b1;
                    use_skid  = 1'b1;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                // Old address is kept so the outstanding request stays stable until its ack
                o_imem_req  = 1'b1;
                o_imem_addr = r_drain_addr;
                if (i_imem_ack) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ld_instr = use_skid ? skid_q.instr : i_imem_rdata;
    assign ld_pc    = use_skid ? skid_q.pc    : i_pc;
    assign ld_pc4   = ld_pc + PC_STEP;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            skid_q       <= '0;
            r_drain_addr <= '0;
        end else begin
            if (skid_load)  skid_q       <= '{instr: i_imem_rdata, pc: i_pc};
            if (drain_load) r_drain_addr <= i_pc;
        end
    end

    ifid_reg u_ifid (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .consume (ifid_consume),
        .d_instr (ld_instr),
        .d_pc    (ld_pc),
        .d_pc4   (ld_pc4),
        .valid   (o_ifid_valid),
        .instr   (o_ifid_instr),
        .pc      (o_ifid_pc),
        .pc4     (o_ifid_pc4)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) o_exc_misalign <= 1'b0;
        else         o_exc_misalign <= redirect_fire && (i_redirect_pc[1:0] != 2'b00);
    end
`else
    assign o_exc_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; the bench models the PC register and imem data.
module tb_instr_fetch;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic [31:0] i_pc;
    logic [31:0] o_pc_next;
    logic        o_pc_hold;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_id_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_ifid_valid;
    logic [31:0] o_ifid_instr;
    logic [31:0] o_ifid_pc;
    logic [31:0] o_ifid_pc4;
    logic        o_exc_misalign;

    int n_chk = 0;
    int n_bad = 0;
    logic exp_mis;

    always #5 i_clk = ~i_clk;

    // Instruction word at address a is ~a
    assign i_imem_rdata = ~o_imem_addr;

    instr_fetch dut (
        .i_clk          (i_clk),
        .i_nrst         (i_nrst),
        .i_pc           (i_pc),
        .o_pc_next      (o_pc_next),
        .o_pc_hold      (o_pc_hold),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_rdata   (i_imem_rdata),
        .i_id_stall     (i_id_stall),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_ifid_valid   (o_ifid_valid),
        .o_ifid_instr   (o_ifid_instr),
        .o_ifid_pc      (o_ifid_pc),
        .o_ifid_pc4     (o_ifid_pc4),
        .o_exc_misalign (o_exc_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock: PC register loads (word-truncated) unless held; returns at posedge+2
    task automatic tick();
        logic        h;
        logic [31:0] n;
        @(negedge i_clk);
        h = o_pc_hold;
        n = o_pc_next;
        @(posedge i_clk);
        #1;
        if (!h) i_pc = n & 32'hFFFF_FFFC;
        #1;
    endtask

    initial begin
`ifdef FETCH_MISALIGN_CHK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        i_nrst = 1'b0; i_pc = 32'h0; i_imem_ack = 1'b0; i_id_stall = 1'b0;
        i_redirect = 1'b0; i_redirect_pc = 32'h0;
        #1;
        check("rst_req",   32'(o_imem_req),     32'h0);
        check("rst_addr",  o_imem_addr,         32'h0);
        check("rst_pcn",   o_pc_next,           32'h0);
        check("rst_hold",  32'(o_pc_hold),      32'h1);
        check("rst_valid", 32'(o_ifid_valid),   32'h0);
        check("rst_instr", o_ifid_instr,        32'h0);
        check("rst_pc",    o_ifid_pc,           32'h0);
        check("rst_pc4",   o_ifid_pc4,          32'h0);
        check("rst_mis",   32'(o_exc_misalign), 32'h0);

        // Reset release with ack tied high: back-to-back fetch
        @(posedge i_clk); #1;
        i_nrst = 1'b1; i_imem_ack = 1'b1;
        #1;
        check("idle_hold", 32'(o_pc_hold),  32'h1);
        check("idle_req",  32'(o_imem_req), 32'h0);
        tick();
        check("f0_req",   32'(o_imem_req),   32'h1);
        check("f0_addr",  o_imem_addr,       32'h0);
        check("f0_pcn",   o_pc_next,         32'h4);
        check("f0_valid", 32'(o_ifid_valid), 32'h0);
        tick();
        check("f1_addr",  o_imem_addr,       32'h4);
        check("f1_ipc",   o_ifid_pc,         32'h0);
        check("f1_ipc4",  o_ifid_pc4,        32'h4);
        check("f1_instr", o_ifid_instr,      32'hFFFF_FFFF);
        check("f1_valid", 32'(o_ifid_valid), 32'h1);
        tick();
        check("f2_addr",  o_imem_addr, 32'h8);
        check("f2_ipc",   o_ifid_pc,   32'h4);

        // Decode stall with ack at 0x8: instruction goes to skid
        i_id_stall = 1'b1;
        tick();
        check("sk_req",   32'(o_imem_req),   32'h0);
        check("sk_hold",  32'(o_pc_hold),    32'h1);
        check("sk_pc",    i_pc,              32'hC);
        check("sk_ipc",   o_ifid_pc,         32'h4);
        check("sk_valid", 32'(o_ifid_valid), 32'h1);
        tick();
        check("sk2_req",  32'(o_imem_req), 32'h0);
        check("sk2_ipc",  o_ifid_pc,       32'h4);
        i_id_stall = 1'b0;
        tick();
        check("un_ipc",   o_ifid_pc,    32'h8);
        check("un_instr", o_ifid_instr, 32'hFFFF_FFF7);
        check("un_ipc4",  o_ifid_pc4,   32'hC);
        check("un_req",   32'(o_imem_req), 32'h1);
        check("un_addr",  o_imem_addr,  32'hC);

        // Redirect while request at 0xC is waiting: drain old fetch
        i_imem_ack = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h100;
        #1;
        check("rd_pcn",  o_pc_next,       32'h100);
        check("rd_hold", 32'(o_pc_hold),  32'h0);
        tick();
        i_redirect = 1'b0;
        #1;
        check("dr_req",   32'(o_imem_req),   32'h1);
        check("dr_addr",  o_imem_addr,       32'hC);
        check("dr_hold",  32'(o_pc_hold),    32'h1);
        check("dr_valid", 32'(o_ifid_valid), 32'h0);
        tick();
        check("dr2_addr", o_imem_addr, 32'hC);
        i_imem_ack = 1'b1;
        #1;
        check("dr3_addr", o_imem_addr, 32'hC);
        tick();
        check("pd_valid", 32'(o_ifid_valid), 32'h0);
        check("pd_addr",  o_imem_addr,       32'h100);
        check("pd_req",   32'(o_imem_req),   32'h1);
        tick();
        check("t_ipc",    o_ifid_pc,         32'h100);
        check("t_valid",  32'(o_ifid_valid), 32'h1);

        // Redirect, ack and stall together: flush wins
        i_redirect = 1'b1; i_redirect_pc = 32'h200; i_id_stall = 1'b1;
        tick();
        i_redirect = 1'b0; i_id_stall = 1'b0;
        #1;
        check("co_valid", 32'(o_ifid_valid), 32'h0);
        check("co_addr",  o_imem_addr,       32'h200);
        check("co_req",   32'(o_imem_req),   32'h1);

        // Address wrap at top of memory
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        #1;
        check("wr_addr", o_imem_addr,      32'hFFFF_FFFC);
        check("wr_pcn",  o_pc_next,        32'h0);
        check("wr_hold", 32'(o_pc_hold),   32'h0);
        tick();
        check("wr_ipc",   o_ifid_pc,    32'hFFFF_FFFC);
        check("wr_ipc4",  o_ifid_pc4,   32'h0);
        check("wr_instr", o_ifid_instr, 32'h3);
        check("wr_next",  o_imem_addr,  32'h0);

        // Misaligned redirect target
        check("mis_pre", 32'(o_exc_misalign), 32'h0);
        i_redirect = 1'b1; i_redirect_pc = 32'h102;
        tick();
        i_redirect = 1'b0;
        #1;
        check("mis_pulse", 32'(o_exc_misalign), 32'(exp_mis));
        check("mis_addr",  o_imem_addr,         32'h100);
        tick();
        check("mis_clear", 32'(o_exc_misalign), 32'h0);
        check("mis_valid", 32'(o_ifid_valid),   32'h1);

        // Asynchronous reset mid-operation
        i_nrst = 1'b0;
        #1;
        check("ar_valid", 32'(o_ifid_valid), 32'h0);
        check("ar_req",   32'(o_imem_req),   32'h0);
        check("ar_hold",  32'(o_pc_hold),    32'h1);
        check("ar_ipc",   o_ifid_pc,         32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the MIPS pipeline, placed between the program-counter register and the decode stage. It drives the PC register's next-value and hold inputs and runs the req/ack handshake to instruction memory. It owns the IF/ID pipeline register and a one-entry skid buffer. It also handles decode back-pressure and branch/jump redirects, including flushing wrong-path fetches.

## Interface
- No parameters.
- i_clk  in  1  clock; all state updates on rising edge
- i_nrst  in  1  reset, asynchronous, active-low
- i_pc  in  32  current PC from the PC register (word-aligned)
- o_pc_next  out  32  next PC value to the PC register
- o_pc_hold  out  1  1 = PC register holds; 0 = PC register loads o_pc_next at the next edge
- o_imem_req  out  1  fetch request
- o_imem_addr  out  32  fetch address
- i_imem_ack  in  1  fetch done this cycle; i_imem_rdata valid
- i_imem_rdata  in  32  instruction word
- i_id_stall  in  1  decode cannot accept a new IF/ID entry
- i_redirect  in  1  branch/jump resolved; flush and refetch
- i_redirect_pc  in  32  redirect target
- o_ifid_valid  out  1  IF/ID entry valid
- o_ifid_instr  out  32  fetched instruction
- o_ifid_pc  out  32  address of o_ifid_instr
- o_ifid_pc4  out  32  o_ifid_pc + 4
- o_exc_misalign  out  1  misaligned redirect target (see Configuration)

## Operation
- States:
  - IDLE: one cycle after reset; no request.
  - REQ: request active.
  - SKID: instruction parked; decode blocked.
  - DRAIN: discarding a wrong-path fetch.
- Accept condition: accept = !o_ifid_valid || !i_id_stall.
- IDLE -> REQ unconditionally. o_pc_hold=1.
- REQ: o_imem_req=1, o_imem_addr=i_pc.
  - No ack: o_pc_hold=1.
  - Ack with accept: IF/ID <= {rdata, i_pc, i_pc+4}, valid=1. o_pc_next=i_pc+4, o_pc_hold=0. Stay in REQ, giving back-to-back fetch at 1 instruction/cycle.
  - Ack without accept: skid <= {rdata, i_pc}. PC advances as above. Go to SKID.
- SKID: o_imem_req=0, o_pc_hold=1. On accept, IF/ID <= skid and go to REQ.
- Decode consumes (valid && !i_id_stall) and no new entry is loaded: valid <= 0.
- Redirect has priority over every other event, including ID stall, ack, and skid:
  - o_pc_next=i_redirect_pc, o_pc_hold=0.
  - IF/ID valid <= 0; skid discarded.
  - In REQ without ack: capture r_drain_addr=i_pc and go to DRAIN.
  - Otherwise go to REQ.
- DRAIN: o_imem_req=1, o_imem_addr=r_drain_addr, o_pc_hold=1.
  - On ack: data discarded, go to REQ.
  - A further redirect in DRAIN updates the PC only; the state stays DRAIN.
- Address arithmetic: 32-bit modulo. 0xFFFFFFFC + 4 = 0x00000000. No carry out.

## Timing
- Reset values: state IDLE, o_imem_req=0, o_imem_addr=0, o_pc_next=0, o_pc_hold=1, o_ifid_valid=0, o_ifid_instr=0, o_ifid_pc=0, o_ifid_pc4=0, o_exc_misalign=0.
- Outputs and next state are decoded from registered state and current inputs. IF/ID, skid, r_drain_addr, and state are registered.
- Ack is accepted combinationally in the same cycle as req.
- Latency: ack edge to o_ifid_valid is 1 cycle. Redirect edge to first request at the target is 1 cycle, or after the drain ack.
- o_imem_req and o_imem_addr stay stable from assertion until ack. Exception: REQ with a redirect and no ack, where DRAIN keeps the old address.
- Reset mid-operation clears everything asynchronously. An outstanding memory request is abandoned; memory must drop it.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with i_redirect_pc[1:0] != 0 sets o_exc_misalign=1 for exactly one cycle after the redirect edge.
  - The redirect is still applied; the PC register truncates bits [1:0].
- Undefined: o_exc_misalign tied to 0; no check logic.

## Structure
- Shared package mips_pkg holds:
  - the fetch state enum (IDLE, REQ, SKID, DRAIN);
  - RESET_PC = 32'h0;
  - PC_STEP = 32'd4;
  - INSTR_W = 32.
- Sub-module ifid_reg: the IF/ID register with load, flush, and consume controls. It is reused by later pipeline registers.

## Test plan
- Reset release, ack tied 1: req at 0x0, 0x4, 0x8 on consecutive cycles. o_ifid_pc follows with 1-cycle lag. o_ifid_pc4 = pc+4.
- i_id_stall=1 with a valid entry, ack at 0x8: state SKID, req=0, PC held at 0xC. Release stall: IF/ID shows 0x8, then req at 0xC.
- In REQ with ack delayed 3 cycles, redirect to 0x100: DRAIN keeps addr at old PC until ack. Data discarded, o_ifid_valid=0. Next req at 0x100.
- Redirect, ack, and i_id_stall in the same cycle: flush wins, no IF/ID load, next req at the redirect target.
- PC 0xFFFFFFFC with ack: o_pc_next=0x00000000, o_ifid_pc4=0x00000000.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102: o_exc_misalign pulses 1 cycle. Without the macro it stays 0.
